// File: rtl/lfsr_stim_misr_bank_if.sv
// Stimulus/response bundle between the LFSR/MISR harness and whoever drives it.
// The harness is the slave: it consumes run control and response, and produces stimulus and signature.
interface lfsr_stim_misr_bank_if #(
    parameter int NUM_CH     = 4,
    parameter int STIM_WIDTH = 56,
    parameter int RESP_WIDTH = 64
);
    logic                         start;
    logic                         pause;
    logic                         step;
    logic [RESP_WIDTH-1:0]        resp;
    logic [NUM_CH*STIM_WIDTH-1:0] stim;
    logic                         stim_valid;
    logic [RESP_WIDTH-1:0]        sig;
    logic                         done;
    logic [31:0]                  cycle_cnt;

    modport master (
        output start, pause, step, resp,
        input  stim, stim_valid, sig, done, cycle_cnt
    );

    modport slave (
        input  start, pause, step, resp,
        output stim, stim_valid, sig, done, cycle_cnt
    );
endinterface

// File: rtl/lfsr_stim_misr_bank.sv
// Out-of-context harness: per-channel 64-bit LFSR stimulus and a rotate-XOR MISR
// that compacts the response over a bounded run, with start/pause/step control.
module lfsr_stim_misr_bank #(
    parameter int          NUM_CH     = 4,
    parameter int          STIM_WIDTH = 56,
    parameter int          RESP_WIDTH = 64,
    parameter logic [31:0] SEED       = 32'h0000_0000,
    parameter int unsigned RUN_LEN    = 1024
) (
    input logic                  clk,
    input logic                  reset,
    lfsr_stim_misr_bank_if.slave bus
);

    localparam int          WORDS    = (STIM_WIDTH + 63) / 64;
    localparam int          NW       = NUM_CH * WORDS;
    localparam logic [63:0] GOLDEN   = 64'h9E37_79B9_7F4A_7C15;
    localparam bit          FINITE   = (RUN_LEN != 0);
    localparam logic [31:0] LAST_CNT = FINITE ? 32'(RUN_LEN - 1) : 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Word k of channel c sits at flat index c*WORDS+k; a zero seed would lock the LFSR.
    function automatic logic [NW*64-1:0] seed_vec();
        logic [NW*64-1:0] v;
        logic [63:0]      s;
        v = '0;
        for (int i = 0; i < NW; i++) begin
            s = GOLDEN ^ ({32'h0000_0000, SEED} << 16) ^ 64'(((i / WORDS) * 8) + (i % WORDS) + 1);
            v[i*64 +: 64] = (s == 64'h0) ? 64'h1 : s;
        end
        return v;
    endfunction

    function automatic logic [63:0] lfsr_next(input logic [63:0] s);
        return {s[62:0], s[63] ^ s[62] ^ s[60] ^ s[59]};
    endfunction

    function automatic logic [RESP_WIDTH-1:0] misr_next(input logic [RESP_WIDTH-1:0] s,
                                                        input logic [RESP_WIDTH-1:0] r);
        return {s[RESP_WIDTH-2:0], s[RESP_WIDTH-1]} ^ r;
    endfunction

    localparam logic [NW*64-1:0] SEEDS = seed_vec();

    state_t                 state_r;
    state_t                 state_s;
    logic                   load_s;
    logic                   adv_s;
    logic [NW*64-1:0]       lfsr_r;
    logic [NW*64-1:0]       lfsr_adv_s;
    logic [RESP_WIDTH-1:0]  sig_r;
    logic [31:0]            cnt_r;
    logic                   done_r;
    logic                   valid_r;

    // Next-state and datapath strobes; start outranks both advance and completion.
    always_comb begin
        state_s = state_r;
        load_s  = 1'b0;
        adv_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    load_s  = 1'b1;
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (bus.start) begin
                    load_s  = 1'b1;
                    state_s = ST_RUN;
                end else if (!bus.pause || bus.step) begin
                    adv_s = 1'b1;
                    if (FINITE && (cnt_r == LAST_CNT)) begin
                        state_s = ST_DONE;
                    end else begin
                        state_s = ST_RUN;
                    end
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_DONE: begin
                if (bus.start) begin
                    load_s  = 1'b1;
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_DONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // One Fibonacci step for every LFSR word in every channel.
    always_comb begin
        lfsr_adv_s = lfsr_r;
        for (int w = 0; w < NW; w++) begin
            lfsr_adv_s[w*64 +: 64] = lfsr_next(lfsr_r[w*64 +: 64]);
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // LFSR bank, signature and advance counter; all reload together on start.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lfsr_r <= SEEDS;
            sig_r  <= '0;
            cnt_r  <= 32'h0000_0000;
        end else if (load_s) begin
            lfsr_r <= SEEDS;
            sig_r  <= '0;
            cnt_r  <= 32'h0000_0000;
        end else if (adv_s) begin
            lfsr_r <= lfsr_adv_s;
            sig_r  <= misr_next(sig_r, bus.resp);
            cnt_r  <= cnt_r + 32'h0000_0001;
        end else begin
            lfsr_r <= lfsr_r;
            sig_r  <= sig_r;
            cnt_r  <= cnt_r;
        end
    end

    // Status flags registered from the next state so they line up with state_r.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            done_r  <= 1'b0;
            valid_r <= 1'b0;
        end else begin
            done_r  <= (state_s == ST_DONE);
            valid_r <= (state_s == ST_RUN);
        end
    end

    // Channels are LSB-aligned over their words; bits beyond STIM_WIDTH stay internal.
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        assign bus.stim[c*STIM_WIDTH +: STIM_WIDTH] = lfsr_r[c*WORDS*64 +: STIM_WIDTH];
    end

    assign bus.stim_valid = valid_r;
    assign bus.sig        = sig_r;
    assign bus.done       = done_r;
    assign bus.cycle_cnt  = cnt_r;

endmodule

// File: doc/lfsr_stim_misr_bank.md
Name: lfsr_stim_misr_bank

Overview:
- Parametrised out-of-context stimulus/response harness for benchmark designs.
- Generates NUM_CH independent pseudo-random stimulus channels of STIM_WIDTH bits from 64-bit LFSRs.
- Compacts the DUT response into a MISR signature over a bounded run, so no DUT logic can be optimised away.
- Adds run control (start/pause/single-step/run length) and a done flag.

Parameters:
- NUM_CH, 4: number of stimulus channels (>=1).
- STIM_WIDTH, 56: bits per channel (>=1, any value; built from ceil(STIM_WIDTH/64) LFSR words, LSB-aligned, truncated).
- RESP_WIDTH, 64: DUT response / signature width (>=2).
- SEED, 0: 32-bit global seed offset.
- RUN_LEN, 1024: number of advances per run; 0 = run forever.

Ports:
- clk  input  1  sole clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  synchronous pulse; (re)starts a run from seeds.
- pause  input  1  when high in RUN, LFSRs/MISR/counter hold.
- step  input  1  when pause is high, a one-cycle pulse advances exactly once.
- resp  input  RESP_WIDTH  DUT response to the current stim.
- stim  output  NUM_CH*STIM_WIDTH  channel c occupies [c*STIM_WIDTH +: STIM_WIDTH].
- stim_valid  output  1  high while state is RUN.
- sig  output  RESP_WIDTH  MISR signature.
- done  output  1  high in DONE.
- cycle_cnt  output  32  number of advances in the current run.

Behaviour:
- Seed for word k of channel c: S = 64'h9E3779B97F4A7C15 ^ (SEED << 16) ^ (c*8 + k + 1). If S == 0, use 64'h1.
- LFSR step (Fibonacci, x^64+x^63+x^61+x^60+1): s_next = {s[62:0], s[63]^s[62]^s[60]^s[59]}.
- stim is the registered LFSR contents (no combinational path from inputs).
- FSM states: IDLE, RUN, DONE.
- Reset (async assert, any time, including mid-run):
  - state=IDLE, all LFSRs = seeds, sig=0, cycle_cnt=0, done=0, stim_valid=0.
  - stim shows the seed words.
- IDLE: start=1 -> RUN at the next edge. At that edge, LFSRs reload seeds, sig=0, cycle_cnt=0.
- RUN:
  - advance = !pause | (pause & step).
  - On each clk edge with advance=1:
    - every LFSR steps once;
    - sig <= {sig[RESP_WIDTH-2:0], sig[RESP_WIDTH-1]} ^ resp, where resp is sampled against the stim presented before that edge;
    - cycle_cnt <= cycle_cnt + 1 (wraps at 2^32).
  - advance=0: all hold.
  - If advance and cycle_cnt == RUN_LEN-1 (RUN_LEN != 0) -> DONE at the same edge; the last update is included.
- DONE: stim, sig and cycle_cnt frozen; done=1; pause/step ignored.
- start=1 in RUN or DONE: restart (same actions as IDLE->RUN). start has priority over advance and completion in the same cycle.
- Latency:
  - start edge -> stim=seed, stim_valid=1 on the next cycle.
  - First advance occurs at the following edge.
- step while pause=0 is ignored (no double advance).

Test Plan:
1. NUM_CH=1, STIM_WIDTH=64, SEED=0; release reset -> stim=64'h9E3779B97F4A7C14, state IDLE, done=0, sig=0. Pulse start, one free-run advance -> stim=64'h3C6EF372FE94F829, cycle_cnt=1.
2. RUN_LEN=4, resp tied 0, start, pause=0 -> stim_valid high exactly 4 cycles; done=1 and cycle_cnt=4 afterwards; sig=0; stim frozen at 4th successor of seed.
3. RUN_LEN=3, RESP_WIDTH=8, resp driven 8'h01, 8'h02, 8'h04 on successive advances -> sig goes 8'h01, 8'h00, 8'h04 (rotate then XOR).
4. pause=1 mid-run for 10 cycles with two step pulses -> cycle_cnt increments by exactly 2, stim changes twice, sig updated twice; step with pause=0 gives no extra advance.
5. NUM_CH=3, STIM_WIDTH=100 -> every channel seed differs; channel 1 word 1 equals S with c=1, k=1; bits 100+ absent; no channel ever all-zero over 1000 advances.
6. Assert reset low mid-run (asynchronous, between edges) -> outputs return to reset values immediately. Start in DONE -> cycle_cnt=0, sig=0, stim=seed, done=0 next cycle.
